// File: rtl/soc_xbar_pkg.sv
// Shared types and helpers for the SoC data crossbar.
// Configuration macro consumed by soc_data_xbar: SOC_XBAR_TIMEOUT_EN.
package soc_xbar_pkg;

  // Upper bound on the number of targets; one extra index encodes the ERR target.
  localparam int XbarMaxDev = 8;

  typedef logic [$clog2(XbarMaxDev+1)-1:0] tgt_idx_t;

  // Request fields broadcast to every target.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xbar_req_t;

  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/soc_xbar_decode.sv
// Combinational priority address decoder: lowest matching target wins,
// no match selects the internal ERR target (index NumDev).
module soc_xbar_decode
  import soc_xbar_pkg::*;
#(
  parameter int unsigned               NumDev  = 4,
  parameter logic [NumDev-1:0][31:0]   DevBase = {NumDev{32'h0}},
  parameter logic [NumDev-1:0][31:0]   DevMask = {NumDev{32'hFFFF_E000}}
) (
  input  logic [31:0] addr_i,
  output tgt_idx_t    sel_o,
  output logic        hit_o
);

  // Walk from the highest index down so the lowest match overwrites last.
  always_comb begin
    sel_o = tgt_idx_t'(NumDev);
    hit_o = 1'b0;
    for (int i = int'(NumDev) - 1; i >= 0; i--) begin
      if (addr_match(addr_i, DevBase[i], DevMask[i])) begin
        sel_o = tgt_idx_t'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_data_xbar.sv
// Ibex data-port crossbar: routes OBI-style requests to NumDev targets with
// in-order responses. Outstanding transactions always target a single device,
// so switching targets waits for the pipe to drain. Unmapped addresses get a
// one-cycle-later error response from an internal ERR target.
// Optional feature: define SOC_XBAR_TIMEOUT_EN to complete hung transactions
// with an error after TimeoutCycles cycles without a response.
module soc_data_xbar
  import soc_xbar_pkg::*;
#(
  parameter int unsigned             NumDev        = 4,
  parameter int unsigned             MaxOutst      = 4,
  parameter logic [NumDev-1:0][31:0] DevBase       = {NumDev{32'h0}},
  parameter logic [NumDev-1:0][31:0] DevMask       = {NumDev{32'hFFFF_E000}},
  parameter int unsigned             TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // Host (Ibex data port)
  input  logic                     host_req_i,
  output logic                     host_gnt_o,
  input  logic                     host_we_i,
  input  logic [3:0]               host_be_i,
  input  logic [31:0]              host_addr_i,
  input  logic [31:0]              host_wdata_i,
  output logic                     host_rvalid_o,
  output logic [31:0]              host_rdata_o,
  output logic                     host_err_o,
  // Devices
  output logic [NumDev-1:0]        dev_req_o,
  input  logic [NumDev-1:0]        dev_gnt_i,
  output logic                     dev_we_o,
  output logic [3:0]               dev_be_o,
  output logic [31:0]              dev_addr_o,
  output logic [31:0]              dev_wdata_o,
  input  logic [NumDev-1:0]        dev_rvalid_i,
  input  logic [NumDev-1:0][31:0]  dev_rdata_i,
  output logic                     spurious_o
);

  localparam int unsigned     OutW     = $clog2(MaxOutst + 1);
  localparam logic [OutW-1:0] OutstMax = OutW'(MaxOutst);

  // Elaboration-time parameter sanity checks.
  if (NumDev < 1 || NumDev > XbarMaxDev) begin : g_bad_numdev
    $error("soc_data_xbar: NumDev must be in 1..%0d", XbarMaxDev);
  end
  if (MaxOutst < 1 || (MaxOutst & (MaxOutst - 1)) != 0) begin : g_bad_maxoutst
    $error("soc_data_xbar: MaxOutst must be a power of two >= 1");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("soc_data_xbar: TimeoutCycles must be >= 1");
  end

  tgt_idx_t        r_cur_tgt;
  logic [OutW-1:0] r_outst;
  logic            r_err_pulse;
  logic            r_spurious;

  tgt_idx_t        w_sel;
  logic            w_hit;
  logic [NumDev-1:0] w_sel_oh;
  logic [NumDev-1:0] w_cur_oh;
  logic            w_dev_rvalid;
  logic [31:0]     w_dev_rdata;
  logic            w_tmo_fire;
  logic            w_resp;
  logic [OutW-1:0] w_outst_eff;
  logic            w_can_accept;
  logic            w_grant;
  logic [OutW-1:0] w_outst_nxt;
  xbar_req_t       w_req;

  soc_xbar_decode #(
    .NumDev  (NumDev),
    .DevBase (DevBase),
    .DevMask (DevMask)
  ) u_decode (
    .addr_i (host_addr_i),
    .sel_o  (w_sel),
    .hit_o  (w_hit)
  );

  // Broadcast request fields straight through to all targets.
  assign w_req       = '{we: host_we_i, be: host_be_i, addr: host_addr_i, wdata: host_wdata_i};
  assign dev_we_o    = w_req.we;
  assign dev_be_o    = w_req.be;
  assign dev_addr_o  = w_req.addr;
  assign dev_wdata_o = w_req.wdata;

  // One-hot views of the decoded target and of the target owning outstanding work.
  always_comb begin
    w_sel_oh = '0;
    w_cur_oh = '0;
    for (int i = 0; i < int'(NumDev); i++) begin
      w_sel_oh[i] = w_hit && (w_sel == tgt_idx_t'(i));
      w_cur_oh[i] = (r_outst != '0) && (r_cur_tgt == tgt_idx_t'(i));
    end
  end

  // Select the response path of the device that owns the outstanding transactions.
  always_comb begin
    w_dev_rdata = '0;
    for (int i = 0; i < int'(NumDev); i++) begin
      if (w_cur_oh[i]) w_dev_rdata = dev_rdata_i[i];
    end
  end

  assign w_dev_rvalid = |(w_cur_oh & dev_rvalid_i);

`ifdef SOC_XBAR_TIMEOUT_EN
  localparam int unsigned     TmoW   = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoEnd = TmoW'(TimeoutCycles - 1);

  logic [TmoW-1:0] r_tmo_cnt;

  // A late real response from a timed-out device is indistinguishable from the
  // next in-order response while work is still pending; once drained it is spurious.
  assign w_tmo_fire = (r_outst != '0) && (r_cur_tgt != tgt_idx_t'(NumDev)) &&
                      !w_dev_rvalid && (r_tmo_cnt == TmoEnd);

  // Count idle cycles while work is pending; any response restarts the window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
    end else if (r_outst == '0 || host_rvalid_o) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo_fire = 1'b0;
`endif

  // Response mux: device data, registered ERR pulse, or timeout completion.
  assign w_resp        = w_dev_rvalid | r_err_pulse | w_tmo_fire;
  assign host_rvalid_o = w_resp;
  assign host_err_o    = r_err_pulse | w_tmo_fire;
  assign host_rdata_o  = w_dev_rvalid ? w_dev_rdata : '0;

  // A response this cycle frees its slot, so a full or draining pipe may accept now.
  assign w_outst_eff  = r_outst - OutW'(w_resp);
  assign w_can_accept = !rst_i && (w_outst_eff != OutstMax) &&
                        ((w_outst_eff == '0) || (w_sel == r_cur_tgt));

  assign dev_req_o  = {NumDev{w_can_accept && host_req_i}} & w_sel_oh;
  assign host_gnt_o = w_can_accept && host_req_i && (w_hit ? |(w_sel_oh & dev_gnt_i) : 1'b1);
  assign w_grant    = host_gnt_o;

  // Outstanding count: grant and response in the same cycle cancel out.
  always_comb begin
    w_outst_nxt = r_outst;
    case ({w_grant, w_resp})
      2'b10:   w_outst_nxt = r_outst + 1'b1;
      2'b01:   w_outst_nxt = r_outst - 1'b1;
      default: w_outst_nxt = r_outst;
    endcase
  end

  // Transaction bookkeeping, ERR response pulse and sticky spurious flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cur_tgt   <= '0;
      r_outst     <= '0;
      r_err_pulse <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      if (w_grant) r_cur_tgt <= w_sel;
      r_outst     <= w_outst_nxt;
      r_err_pulse <= w_grant && !w_hit;
      if (|(dev_rvalid_i & ~w_cur_oh)) r_spurious <= 1'b1;
    end
  end

  assign spurious_o = r_spurious;

endmodule

// File: tb/tb_soc_data_xbar.sv
// Directed bench for soc_data_xbar (NumDev=2, MaxOutst=4) with a queue-based
// reference model checked every cycle plus hand-computed literal expectations.
module tb_soc_data_xbar;

  localparam int unsigned TMO  = 16;
  localparam logic [31:0] MASK = 32'hFFFF_E000;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [3:0]        host_be;
  logic [31:0]       host_addr, host_wdata, host_rdata;
  logic [1:0]        dev_req, dev_gnt, dev_rvalid;
  logic              dev_we;
  logic [3:0]        dev_be;
  logic [31:0]       dev_addr, dev_wdata;
  logic [1:0][31:0]  dev_rdata;
  logic              spurious;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  soc_data_xbar #(
    .NumDev        (2),
    .MaxOutst      (4),
    .DevBase       ({32'h0000_2000, 32'h0000_0000}),
    .DevMask       ({2{32'hFFFF_E000}}),
    .TimeoutCycles (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host_req_i    (host_req),
    .host_gnt_o    (host_gnt),
    .host_we_i     (host_we),
    .host_be_i     (host_be),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .host_err_o    (host_err),
    .dev_req_o     (dev_req),
    .dev_gnt_i     (dev_gnt),
    .dev_we_o      (dev_we),
    .dev_be_o      (dev_be),
    .dev_addr_o    (dev_addr),
    .dev_wdata_o   (dev_wdata),
    .dev_rvalid_i  (dev_rvalid),
    .dev_rdata_i   (dev_rdata),
    .spurious_o    (spurious)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   q[$];          // target of each outstanding txn, in order (2 = ERR)
  bit   err_due = 0;   // ERR response owed this cycle
  bit   m_spur  = 0;   // expected sticky spurious flag
  int   m_cnt   = 0;   // cycles without response while work pending

  always @(negedge clk) begin : model
    int          sel, qs;
    logic        acc, exp_gnt, exp_rv, exp_err, real_rv, tmo, spur_in;
    logic [1:0]  exp_req;
    logic [31:0] exp_rd;
    if ((host_addr & MASK) == 32'h0)         sel = 0;
    else if ((host_addr & MASK) == 32'h2000) sel = 1;
    else                                      sel = 2;
    if (rst) begin
      chk("rst_gnt", {31'b0, host_gnt}, 0);
      chk("rst_rvalid", {31'b0, host_rvalid}, 0);
      chk("rst_err", {31'b0, host_err}, 0);
      chk("rst_rdata", host_rdata, 0);
      chk("rst_dev_req", {30'b0, dev_req}, 0);
      chk("spurious", {31'b0, spurious}, {31'b0, m_spur});
      q.delete();
      err_due = 0;
      m_spur  = 0;
      m_cnt   = 0;
    end else begin
      real_rv = q.size() > 0 && q[0] < 2 && dev_rvalid[q[0]];
      tmo = 1'b0;
`ifdef SOC_XBAR_TIMEOUT_EN
      tmo = q.size() > 0 && q[0] < 2 && !real_rv && m_cnt == TMO - 1;
`endif
      exp_rv  = real_rv || err_due || tmo;
      exp_err = err_due || tmo;
      exp_rd  = real_rv ? dev_rdata[q[0]] : 32'h0;
      qs      = q.size() - (exp_rv ? 1 : 0);
      acc     = qs < 4 && (qs == 0 || q[0] == sel);
      exp_gnt = acc && host_req && (sel == 2 || dev_gnt[sel]);
      exp_req = (acc && host_req && sel < 2) ? 2'(1 << sel) : 2'b00;
      spur_in = 1'b0;
      for (int i = 0; i < 2; i++)
        if (dev_rvalid[i] && !(q.size() > 0 && q[0] == i)) spur_in = 1'b1;
      chk("gnt", {31'b0, host_gnt}, {31'b0, exp_gnt});
      chk("dev_req", {30'b0, dev_req}, {30'b0, exp_req});
      chk("rvalid", {31'b0, host_rvalid}, {31'b0, exp_rv});
      if (exp_rv) begin
        chk("err", {31'b0, host_err}, {31'b0, exp_err});
        chk("rdata", host_rdata, exp_rd);
      end
      chk("spurious", {31'b0, spurious}, {31'b0, m_spur});
      chk("dev_addr", dev_addr, host_addr);
      chk("dev_wdata", dev_wdata, host_wdata);
      chk("dev_we_be", {27'b0, dev_we, dev_be}, {27'b0, host_we, host_be});
      m_cnt = (q.size() == 0 || exp_rv) ? 0 : m_cnt + 1;
      if (exp_rv) void'(q.pop_front());
      if (exp_gnt) q.push_back(sel);
      err_due = exp_gnt && sel == 2;
      m_spur  = m_spur | spur_in;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_be    = 4'hF;
    dev_gnt    = 2'b00;
    dev_rvalid = 2'b00;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [1:0] gnt);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = addr;
    dev_gnt   = gnt;
  endtask

  initial begin
    rst = 1'b1;
    host_addr  = 32'h0;
    host_wdata = 32'h0;
    dev_rdata  = '0;
    idle();
    // Requests during reset must not be granted.
    rd(32'h0, 2'b11);
    step();
    #1 chk("lit_rst_gnt", {31'b0, host_gnt}, 0);
    chk("lit_rst_req", {30'b0, dev_req}, 0);
    step();
    rst = 1'b0;
    idle();

    // 1: three back-to-back reads to dev0, responses one cycle later.
    step(); rd(32'h0, 2'b01);
    #1 chk("t1_gnt0", {31'b0, host_gnt}, 1);
    chk("t1_req0", {30'b0, dev_req}, 2'b01);
    step(); rd(32'h4, 2'b01); dev_rvalid = 2'b01; dev_rdata[0] = 32'h11;
    #1 chk("t1_rv0", {31'b0, host_rvalid}, 1);
    chk("t1_rd0", host_rdata, 32'h11);
    chk("t1_gnt1", {31'b0, host_gnt}, 1);
    step(); rd(32'h8, 2'b01); dev_rdata[0] = 32'h22;
    #1 chk("t1_rd1", host_rdata, 32'h22);
    step(); idle(); dev_rvalid = 2'b01; dev_rdata[0] = 32'h33;
    #1 chk("t1_rd2", host_rdata, 32'h33);
    chk("t1_err", {31'b0, host_err}, 0);
    step(); idle();
    #1 chk("t1_drained", {31'b0, host_rvalid}, 0);

    // 2: target switch stalls until dev0 drains; switch in the drain cycle.
    step(); rd(32'h0, 2'b11);
    #1 chk("t2_gnt0", {31'b0, host_gnt}, 1);
    step(); rd(32'h2004, 2'b11); host_we = 1'b1; host_be = 4'b0011;
    host_wdata = 32'hCAFE_F00D;
    #1 chk("t2_stall", {31'b0, host_gnt}, 0);
    chk("t2_stall_req", {30'b0, dev_req}, 0);
    step(); dev_rvalid = 2'b01; dev_rdata[0] = 32'h55;
    #1 chk("t2_switch_gnt", {31'b0, host_gnt}, 1);
    chk("t2_switch_req", {30'b0, dev_req}, 2'b10);
    chk("t2_rv", {31'b0, host_rvalid}, 1);
    step(); idle(); dev_rvalid = 2'b10; dev_rdata[1] = 32'hAB;
    #1 chk("t2_rd1", host_rdata, 32'hAB);
    step(); idle();

    // 3: unmapped address -> immediate grant, error response next cycle.
    step(); rd(32'h8000_0000, 2'b11);
    #1 chk("t3_gnt", {31'b0, host_gnt}, 1);
    chk("t3_req", {30'b0, dev_req}, 0);
    step(); idle();
    #1 chk("t3_rv", {31'b0, host_rvalid}, 1);
    chk("t3_err", {31'b0, host_err}, 1);
    chk("t3_rdata", host_rdata, 0);
    step();
    #1 chk("t3_rv_done", {31'b0, host_rvalid}, 0);

    // 4: four silent reads fill the pipe; a response frees a slot that cycle.
    for (int k = 0; k < 4; k++) begin
      step(); rd(32'(4 * k), 2'b01);
      #1 chk("t4_fill_gnt", {31'b0, host_gnt}, 1);
    end
    step(); rd(32'h10, 2'b01);
    #1 chk("t4_full", {31'b0, host_gnt}, 0);
    step();
    #1 chk("t4_full2", {31'b0, host_gnt}, 0);
    step(); dev_rvalid = 2'b01; dev_rdata[0] = 32'h100;
    #1 chk("t4_refill", {31'b0, host_gnt}, 1);
    chk("t4_rv", {31'b0, host_rvalid}, 1);
    for (int k = 0; k < 4; k++) begin
      step(); idle(); dev_rvalid = 2'b01; dev_rdata[0] = 32'(32'h101 + k);
      #1 chk("t4_drain", host_rdata, 32'(32'h101 + k));
    end
    step(); idle();
    #1 chk("t4_empty", {31'b0, host_rvalid}, 0);

    // 5: dev1 response with nothing outstanding -> sticky spurious.
    step(); dev_rvalid = 2'b10;
    #1 chk("t5_rv_dropped", {31'b0, host_rvalid}, 0);
    step(); idle();
    #1 chk("t5_spur", {31'b0, spurious}, 1);
    step(); step();
    #1 chk("t5_sticky", {31'b0, spurious}, 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    #1 chk("t5_cleared", {31'b0, spurious}, 0);

    // Reset mid-transaction: the late response is spurious.
    step(); rd(32'h0, 2'b01);
    step(); idle(); rst = 1'b1;
    step(); rst = 1'b0; dev_rvalid = 2'b01;
    #1 chk("rst_late_rv", {31'b0, host_rvalid}, 0);
    step(); idle();
    #1 chk("rst_late_spur", {31'b0, spurious}, 1);

`ifdef SOC_XBAR_TIMEOUT_EN
    // 6: two reads to a silent dev0 time out one per TMO window.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    step(); rd(32'h0, 2'b01);
    step(); rd(32'h4, 2'b01);
    begin
      int n_to;
      int first_at;
      int second_at;
      n_to = 0; first_at = -1; second_at = -1;
      for (int c = 2; c < 60; c++) begin
        step(); idle();
        #1;
        if (host_rvalid && host_err) begin
          if (n_to == 0) first_at = c; else second_at = c;
          n_to++;
        end
      end
      chk("t6_first", 32'(first_at), 32'd16);
      chk("t6_second", 32'(second_at), 32'd32);
      chk("t6_count", 32'(n_to), 32'd2);
    end
`endif

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
